seq_signed_divider: RTL and testbench
=====================================

# seq_signed_divider

Sequential signed integer divider: the inverse-direction companion to the sequential signed multiplier in the arithmetic library. It shares the same `start`/`valid` handshake and operand naming, so the two blocks can be exercised by the same bench style. The block computes `X / Y` by iterative shift-subtract on operand magnitudes, then applies a sign-correction cycle. Results use two's-complement, truncate-toward-zero semantics, so they match Verilog `/` and `%` on signed operands.

## Interface
- `WIDTH`, default 4: operand and result width in bits; must be at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `X`  in  WIDTH signed  dividend; captured on the accepting edge.
- `Y`  in  WIDTH signed  divisor; captured on the accepting edge.
- `busy`  out  1  high while a division is in progress.
- `valid`  out  1  one-cycle pulse; `Q`, `R` and `dbz` are new this cycle.
- `Q`  out  WIDTH signed  quotient; holds its value until the next result.
- `R`  out  WIDTH signed  remainder, with the sign of `X`; holds until the next result.
- `dbz`  out  1  divide-by-zero flag; updated together with `valid`.

## Operation
- Reset (asynchronous): state = IDLE; `busy`, `valid`, `dbz` = 0; `Q`, `R` = 0. All internal registers are cleared.
- IDLE → CALC:
  - Trigger: `start`=1 at an edge (E0).
  - Latch |X| and |Y| as WIDTH-bit unsigned values; -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1).
  - Latch sign_q = X[msb]^Y[msb] and sign_r = X[msb].
  - Clear the partial remainder (WIDTH+1 bits) and load the iteration counter with WIDTH.
  - Set `busy`=1.
- CALC, one step per edge, WIDTH edges total:
  - Shift the next dividend MSB into the partial remainder.
  - Trial-subtract |Y|. If the result is non-negative, keep it and shift 1 into the quotient; otherwise restore and shift 0.
  - Decrement the counter. After the step where the counter reaches 0, go to FIX.
- FIX, one edge:
  - `Q` = sign_q ? −qmag : qmag, truncated to WIDTH bits.
  - `R` = sign_r ? −rmag : rmag.
  - Set `valid`=1 and `busy`=0, then go to IDLE.
- `valid` self-clears on the next edge.
- Overflow: X = −2^(WIDTH-1), Y = −1 gives Q = −2^(WIDTH-1) (wrapped) and R = 0. No flag is raised.
- `start` while `busy`=1 is ignored. `X`/`Y` changes after E0 do not affect the result in flight.
- `start`=1 in the cycle `valid`=1 is accepted, because the state is already IDLE. This gives back-to-back operation with no dead cycle.
- Reset mid-operation aborts immediately. The interrupted division produces no `valid`, and outputs return to reset values.

## Timing
- Latency: `valid` is high in the cycle after edge E0+WIDTH+1, i.e. WIDTH+1 clocks after acceptance (5 clocks at WIDTH=4).
- `busy` is high from after E0 through the edge that raises `valid`.
- Throughput: one division per WIDTH+1 clocks.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `DIV_ZERO_DETECT_EN` defined:
  - Y = 0 at E0 skips CALC and goes directly to result.
  - `valid` and `dbz`=1 are asserted after E0+1.
  - Outputs: Q = −1 (all ones), R = X.
  - `busy` is high for exactly one cycle.
- Not defined:
  - `dbz` is tied 0.
  - Y = 0 runs the normal WIDTH+1 latency. The algorithm naturally gives Q = −1 if X ≥ 0, Q = +1 if X < 0, and R = X.
  - The bench checks exactly these values.

## Test plan
All scenarios use WIDTH=4.
- Reset: hold `rst`=1 with `start` toggling → `busy`=`valid`=`dbz`=0, Q=R=0, no `valid` pulse.
- Sign quadrants, each followed by waiting for `valid`:
  - 7/2 → Q=3, R=1.
  - −7/2 → Q=−3, R=−1.
  - 7/−2 → Q=−3, R=1.
  - −7/−2 → Q=3, R=−1.
  - In every case `valid` is high exactly 5 clocks after acceptance, for one cycle.
- Edge operands:
  - −8/−1 → Q=−8, R=0.
  - −8/1 → Q=−8, R=0.
  - 3/5 → Q=0, R=3.
- Back-to-back and ignored start:
  - 5/7 is followed by `start` with X=−4, Y=3 in the `valid` cycle → second result Q=−1, R=−1, 5 clocks later.
  - A `start` pulsed mid-operation is ignored.
- Reset mid-CALC: assert `rst` at the 2nd CALC cycle of 6/2 → immediate return to reset values. A new 6/2 then yields Q=3, R=0 with normal latency.
- Divide by zero, 5/0:
  - With `DIV_ZERO_DETECT_EN`: `valid` and `dbz`=1 after 1 clock, Q=−1, R=5.
  - Without it: `valid` after 5 clocks, Q=−1, R=5, `dbz`=0.
  - Also −5/0 without the macro → Q=1, R=−5.

Source files
------------

// File: rtl/seq_signed_divider_if.sv
// rtl/seq_signed_divider_if.sv - start/valid handshake and operand/result bundle for seq_signed_divider
interface seq_signed_divider_if #(
    parameter int WIDTH = 4
);
    logic                    start;
    logic signed [WIDTH-1:0] X;
    logic signed [WIDTH-1:0] Y;
    logic                    busy;
    logic                    valid;
    logic signed [WIDTH-1:0] Q;
    logic signed [WIDTH-1:0] R;
    logic                    dbz;

    modport master (output start, X, Y, input busy, valid, Q, R, dbz);
    modport slave  (input start, X, Y, output busy, valid, Q, R, dbz);
endinterface

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - restoring shift-subtract signed divider, truncating toward zero
// Optional feature macro: DIV_ZERO_DETECT_EN (early divide-by-zero result with dbz flag)
module seq_signed_divider #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_signed_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;     // dividend magnitude, shifted out MSB-first; quotient bits enter at LSB
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] r_mag;

    always_comb begin
        x_mag   = bus.X[WIDTH-1] ? unsigned'(-bus.X) : unsigned'(bus.X);
        y_mag   = bus.Y[WIDTH-1] ? unsigned'(-bus.Y) : unsigned'(bus.Y);
        shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs});
        // the remainder magnitude never exceeds 2^(WIDTH-1), so the low WIDTH bits are exact
        r_mag   = rem[WIDTH-1:0];
    end

`ifdef DIV_ZERO_DETECT_EN
    logic dz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dz        <= 1'b0;
            bus.busy  <= 1'b0;
            bus.valid <= 1'b0;
            bus.dbz   <= 1'b0;
            bus.Q     <= '0;
            bus.R     <= '0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvs      <= y_mag;
                        sign_r   <= bus.X[WIDTH-1];
                        cnt      <= CW'(WIDTH);
                        bus.busy <= 1'b1;
                        if (y_mag == '0) begin
                            // result is preloaded so FIX yields Q = -1 and R = X
                            dvd    <= '1;
                            rem    <= {1'b0, x_mag};
                            sign_q <= 1'b0;
                            dz     <= 1'b1;
                            state  <= FIX;
                        end else begin
                            dvd    <= x_mag;
                            rem    <= '0;
                            sign_q <= bus.X[WIDTH-1] ^ bus.Y[WIDTH-1];
                            dz     <= 1'b0;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= fits ? (shifted - {1'b0, dvs}) : shifted;
                    dvd <= {dvd[WIDTH-2:0], fits};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    bus.Q     <= signed'(sign_q ? -dvd : dvd);
                    bus.R     <= signed'(sign_r ? -r_mag : r_mag);
                    bus.dbz   <= dz;
                    bus.valid <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign bus.dbz = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            bus.busy  <= 1'b0;
            bus.valid <= 1'b0;
            bus.Q     <= '0;
            bus.R     <= '0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd      <= x_mag;
                        dvs      <= y_mag;
                        rem      <= '0;
                        sign_q   <= bus.X[WIDTH-1] ^ bus.Y[WIDTH-1];
                        sign_r   <= bus.X[WIDTH-1];
                        cnt      <= CW'(WIDTH);
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // a zero divisor always fits, giving qmag all ones and R = X
                    rem <= fits ? (shifted - {1'b0, dvs}) : shifted;
                    dvd <= {dvd[WIDTH-2:0], fits};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    bus.Q     <= signed'(sign_q ? -dvd : dvd);
                    bus.R     <= signed'(sign_r ? -r_mag : r_mag);
                    bus.valid <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - directed self-checking bench for seq_signed_divider at WIDTH=4
module tb_seq_signed_divider;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    seq_signed_divider_if #(.WIDTH(W)) bus ();

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives start for exactly one rising edge (E0), then scrambles operands.
    task automatic launch(input int x, input int y, input string tag);
        bus.start = 1'b1;
        bus.X     = W'(x);
        bus.Y     = W'(y);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.X     = W'($urandom);
        bus.Y     = W'($urandom);
        check({tag, "_busy_after_E0"}, int'(bus.busy), 1);
    endtask

    // Counts edges until valid is seen (sampled 1 time unit after each edge).
    task automatic wait_result(input int lat, input int eq, input int er, input int edbz, input string tag);
        int k;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                k = i;
                break;
            end
        end
        check({tag, "_latency"}, k, lat);
        check({tag, "_Q"}, int'(bus.Q), eq);
        check({tag, "_R"}, int'(bus.R), er);
        check({tag, "_dbz"}, int'(bus.dbz), edbz);
        check({tag, "_busy_low"}, int'(bus.busy), 0);
    endtask

    task automatic valid_drops(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_valid_one_cycle"}, int'(bus.valid), 0);
    endtask

    initial begin
        int vcount;
        bus.start = 1'b0;
        bus.X     = '0;
        bus.Y     = '0;

        // reset held with start toggling
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.start = ~bus.start;
            bus.X     = 4'sd7;
            bus.Y     = 4'sd2;
            if (bus.valid) vcount++;
        end
        bus.start = 1'b0;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_dbz", int'(bus.dbz), 0);
        check("rst_Q", int'(bus.Q), 0);
        check("rst_R", int'(bus.R), 0);
        check("rst_no_valid_pulse", vcount, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // sign quadrants
        launch(7, 2, "q1");   wait_result(5, 3, 1, 0, "q1");   valid_drops("q1");
        launch(-7, 2, "q2");  wait_result(5, -3, -1, 0, "q2"); valid_drops("q2");
        launch(7, -2, "q3");  wait_result(5, -3, 1, 0, "q3");  valid_drops("q3");
        launch(-7, -2, "q4"); wait_result(5, 3, -1, 0, "q4");  valid_drops("q4");

        // edge operands
        launch(-8, -1, "ovf"); wait_result(5, -8, 0, 0, "ovf");
        launch(-8, 1, "m8p1"); wait_result(5, -8, 0, 0, "m8p1");
        launch(3, 5, "small"); wait_result(5, 0, 3, 0, "small");

        // back-to-back: second start issued in the valid cycle
        launch(5, 7, "b2b_a"); wait_result(5, 0, 5, 0, "b2b_a");
        launch(-4, 3, "b2b_b"); wait_result(5, -1, -1, 0, "b2b_b");

        // start pulsed mid-operation is ignored
        launch(7, 2, "ign");
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.X     = 4'sd1;
        bus.Y     = 4'sd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_result(3, 3, 1, 0, "ign");

        // reset during the second CALC cycle
        launch(6, 2, "abort");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_valid", int'(bus.valid), 0);
        check("abort_Q", int'(bus.Q), 0);
        check("abort_R", int'(bus.R), 0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) vcount++;
        end
        check("abort_no_valid", vcount, 0);
        launch(6, 2, "after_abort"); wait_result(5, 3, 0, 0, "after_abort");

        // divide by zero
`ifdef DIV_ZERO_DETECT_EN
        launch(5, 0, "dz_pos");  wait_result(1, -1, 5, 1, "dz_pos");   valid_drops("dz_pos");
        launch(-5, 0, "dz_neg"); wait_result(1, -1, -5, 1, "dz_neg");
`else
        launch(5, 0, "dz_pos");  wait_result(5, -1, 5, 0, "dz_pos");   valid_drops("dz_pos");
        launch(-5, 0, "dz_neg"); wait_result(5, 1, -5, 0, "dz_neg");
`endif
        launch(-8, 1, "post_dz"); wait_result(5, -8, 0, 0, "post_dz");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
